// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: pops ASCII commands from the RX FIFO, merges them with
// front-panel button pulses into counter controls, and streams status frames to TX.
module uart_cmd_ctrl #(
    parameter bit         ACK_EN   = 1'b1,
    parameter logic [7:0] ACK_CHAR = 8'h3E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_run,
    input  logic        btn_clear,
    input  logic        btn_mode,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic [7:0]  tx_data,
    output logic        tx_push,
    input  logic        tx_full,
    input  logic [15:0] count_bcd,
    output logic        run_en,
    output logic        clear_pulse,
    output logic        mode
);

    typedef enum logic [1:0] {IDLE, DECODE, ACK, REPORT} state_t;

    state_t      state;
    logic [7:0]  cmd_reg;
    logic [2:0]  idx;
    logic        snap_run;
    logic        snap_mode;
    logic [15:0] snap_cnt;
    logic [7:0]  cmd_lc;
    logic        dec_run;
    logic        dec_clear;
    logic        dec_mode;
    logic        dec_stat;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic r,
                                              input logic m, input logic [15:0] cnt);
        case (i)
            3'd0:    return r ? 8'h52 : 8'h50;
            3'd1:    return m ? 8'h44 : 8'h55;
            3'd2:    return digit_char(cnt[15:12]);
            3'd3:    return digit_char(cnt[11:8]);
            3'd4:    return digit_char(cnt[7:4]);
            3'd5:    return digit_char(cnt[3:0]);
            3'd6:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    // Pop and push are combinational so flow control reacts to tx_full/rx_valid
    // in the same cycle; both are masked during reset so an abort pushes nothing.
    always_comb begin
        rx_pop    = !rst && (state == IDLE) && rx_valid;
        tx_push   = !rst && ((state == ACK) || (state == REPORT)) && !tx_full;
        cmd_lc    = cmd_reg | 8'h20;
        dec_run   = (state == DECODE) && (cmd_lc == 8'h72);
        dec_clear = (state == DECODE) && (cmd_lc == 8'h63);
        dec_mode  = (state == DECODE) && (cmd_lc == 8'h6D);
        dec_stat  = (state == DECODE) && (cmd_lc == 8'h73);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_reg     <= '0;
            idx         <= '0;
            snap_run    <= 1'b0;
            snap_mode   <= 1'b0;
            snap_cnt    <= '0;
            tx_data     <= '0;
            run_en      <= 1'b0;
            mode        <= 1'b0;
            clear_pulse <= 1'b0;
        end else begin
            // OR before applying so a button and a same-function command act once
            run_en      <= run_en ^ (btn_run | dec_run);
            mode        <= mode ^ (btn_mode | dec_mode);
            clear_pulse <= btn_clear | dec_clear;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        cmd_reg <= rx_data;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_stat) begin
                        snap_run  <= run_en;
                        snap_mode <= mode;
                        snap_cnt  <= count_bcd;
                        idx       <= '0;
                        tx_data   <= frame_byte(3'd0, run_en, mode, count_bcd);
                        state     <= REPORT;
                    end else if ((dec_run || dec_clear || dec_mode) && ACK_EN) begin
                        tx_data <= ACK_CHAR;
                        state   <= ACK;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACK: begin
                    if (tx_push) begin
                        state <= IDLE;
                    end
                end
                REPORT: begin
                    // tx_data always holds the byte at idx, so it is stable while stalled
                    if (tx_push) begin
                        if (idx == 3'd7) begin
                            state <= IDLE;
                        end else begin
                            idx     <= idx + 3'd1;
                            tx_data <= frame_byte(idx + 3'd1, snap_run, snap_mode, snap_cnt);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: cycle vector table plus report-frame sequences.
module tb_uart_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_run = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_mode = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_pop;
    logic [7:0]  tx_data;
    logic        tx_push;
    logic        tx_full = 1'b0;
    logic [15:0] count_bcd = '0;
    logic        run_en;
    logic        clear_pulse;
    logic        mode;

    int n_cmp = 0;
    int n_bad = 0;

    uart_cmd_ctrl #(.ACK_EN(1'b1), .ACK_CHAR(8'h3E)) dut (
        .clk(clk), .rst(rst), .btn_run(btn_run), .btn_clear(btn_clear),
        .btn_mode(btn_mode), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_pop(rx_pop), .tx_data(tx_data), .tx_push(tx_push), .tx_full(tx_full),
        .count_bcd(count_bcd), .run_en(run_en), .clear_pulse(clear_pulse), .mode(mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rv;
        logic [7:0] rd;
        logic       br, bc, bm, tf;
        logic       e_pop, e_push;
        logic [7:0] e_data;
        logic       chk_data;
        logic       e_run, e_mode, e_clr;
    } vec_t;

    vec_t vt [29];

    function automatic vec_t mk(input logic rv, input logic [7:0] rd, input logic br,
                                input logic bc, input logic bm, input logic tf,
                                input logic e_pop, input logic e_push, input logic [7:0] e_data,
                                input logic chk_data, input logic e_run, input logic e_mode,
                                input logic e_clr);
        vec_t v;
        v.rv = rv; v.rd = rd; v.br = br; v.bc = bc; v.bm = bm; v.tf = tf;
        v.e_pop = e_pop; v.e_push = e_push; v.e_data = e_data; v.chk_data = chk_data;
        v.e_run = e_run; v.e_mode = e_mode; v.e_clr = e_clr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] got [8];
    int got_n;

    // Pops an 's', then collects the frame. stall_at: pushes before a 5-cycle
    // tx_full stall (0 = none); press: btn_run pulse mid-frame; abort_at: pushes
    // before a 1-cycle rst (0 = none).
    task automatic do_report(input string tag, input logic [15:0] bcd, input logic [63:0] frame,
                             input int stall_at, input bit press, input int abort_at);
        int stall_left;
        int gaps;
        bit aborted;
        logic [7:0] eb;
        stall_left = 0;
        gaps = 0;
        aborted = 1'b0;
        got_n = 0;
        @(posedge clk); #1;
        count_bcd = bcd; rx_valid = 1'b1; rx_data = 8'h73;
        #5 chk({tag, "_pop"}, 32'(rx_pop), 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        for (int c = 0; c < 40 && got_n < 8; c++) begin
            @(posedge clk); #1;
            count_bcd = 16'h9999;
            btn_run   = press && (c == 1);
            tx_full   = (stall_left > 0);
            rst       = (abort_at > 0) && (got_n == abort_at);
            #5;
            eb = frame[63 - 8*got_n -: 8];
            if (rst) begin
                chk({tag, "_rst_push"}, 32'(tx_push), 32'd0);
                aborted = 1'b1;
                break;
            end else if (tx_full) begin
                chk({tag, "_stall_push"}, 32'(tx_push), 32'd0);
                chk({tag, "_stall_data"}, 32'(tx_data), 32'(eb));
                stall_left--;
            end else if (tx_push) begin
                got[got_n] = tx_data;
                got_n++;
                if (got_n == stall_at) stall_left = 5;
            end else begin
                gaps++;
            end
        end
        btn_run = 1'b0;
        tx_full = 1'b0;
        chk({tag, "_count"}, 32'(got_n), aborted ? 32'(abort_at) : 32'd8);
        chk({tag, "_gaps"}, 32'(gaps), 32'd0);
        for (int i = 0; i < got_n; i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(frame[63 - 8*i -: 8]));
    endtask

    initial begin
        //          rv rd     br bc bm tf  pop push data   chk run mode clr
        vt[0]  = mk(0, 8'h00, 0, 0, 0, 0,  0,  0,  8'h00, 1,  0,  0,  0);
        vt[1]  = mk(1, 8'h72, 0, 0, 0, 0,  1,  0,  8'h00, 1,  0,  0,  0);
        vt[2]  = mk(0, 8'h00, 0, 0, 0, 0,  0,  0,  8'h00, 0,  0,  0,  0);
        vt[3]  = mk(0, 8'h00, 0, 0, 0, 0,  0,  1,  8'h3E, 1,  1,  0,  0);
        vt[4]  = mk(0, 8'h00, 0, 0, 0, 0,  0,  0,  8'h00, 0,  1,  0,  0);
        vt[5]  = mk(1, 8'h63, 0, 0, 0, 0,  1,  0,  8'h00, 0,  1,  0,  0);
        vt[6]  = mk(0, 8'h00, 0, 1, 0, 0,  0,  0,  8'h00, 0,  1,  0,  0);
        vt[7]  = mk(0, 8'h00, 0, 0, 0, 1,  0,  0,  8'h3E, 1,  1,  0,  1);
        vt[8]  = mk(0, 8'h00, 0, 0, 0, 1,  0,  0,  8'h3E, 1,  1,  0,  0);
        vt[9]  = mk(0, 8'h00, 0, 0, 0, 0,  0,  1,  8'h3E, 1,  1,  0,  0);
        vt[10] = mk(0, 8'h00, 0, 0, 0, 0,  0,  0,  8'h00, 0,  1,  0,  0);
        vt[11] = mk(0, 8'h00, 0, 0, 1, 0,  0,  0,  8'h00, 0,  1,  0,  0);
        vt[12] = mk(0, 8'h00, 0, 0, 0, 0,  0,  0,  8'h00, 0,  1,  1,  0);
        vt[13] = mk(0, 8'h00, 0, 0, 1, 0,  0,  0,  8'h00, 0,  1,  1,  0);
        vt[14] = mk(0, 8'h00, 0, 0, 0, 0,  0,  0,  8'h00, 0,  1,  0,  0);
        vt[15] = mk(1, 8'h78, 0, 0, 0, 0,  1,  0,  8'h00, 0,  1,  0,  0);
        vt[16] = mk(1, 8'h6D, 0, 0, 0, 0,  0,  0,  8'h00, 0,  1,  0,  0);
        vt[17] = mk(1, 8'h6D, 0, 0, 0, 0,  1,  0,  8'h00, 0,  1,  0,  0);
        vt[18] = mk(0, 8'h00, 0, 0, 0, 0,  0,  0,  8'h00, 0,  1,  0,  0);
        vt[19] = mk(0, 8'h00, 0, 0, 0, 0,  0,  1,  8'h3E, 1,  1,  1,  0);
        vt[20] = mk(0, 8'h00, 0, 0, 0, 0,  0,  0,  8'h00, 0,  1,  1,  0);
        vt[21] = mk(1, 8'h52, 0, 0, 0, 0,  1,  0,  8'h00, 0,  1,  1,  0);
        vt[22] = mk(0, 8'h00, 0, 0, 1, 0,  0,  0,  8'h00, 0,  1,  1,  0);
        vt[23] = mk(0, 8'h00, 0, 0, 0, 0,  0,  1,  8'h3E, 1,  0,  0,  0);
        vt[24] = mk(0, 8'h00, 0, 0, 0, 0,  0,  0,  8'h00, 0,  0,  0,  0);
        vt[25] = mk(1, 8'h72, 0, 0, 0, 0,  1,  0,  8'h00, 0,  0,  0,  0);
        vt[26] = mk(0, 8'h00, 0, 0, 1, 0,  0,  0,  8'h00, 0,  0,  0,  0);
        vt[27] = mk(0, 8'h00, 0, 0, 0, 0,  0,  1,  8'h3E, 1,  1,  1,  0);
        vt[28] = mk(0, 8'h00, 0, 0, 0, 0,  0,  0,  8'h00, 0,  1,  1,  0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            rx_valid = vt[i].rv; rx_data = vt[i].rd;
            btn_run = vt[i].br; btn_clear = vt[i].bc; btn_mode = vt[i].bm;
            tx_full = vt[i].tf;
            #5;
            chk($sformatf("v%0d_pop", i),   32'(rx_pop),      32'(vt[i].e_pop));
            chk($sformatf("v%0d_push", i),  32'(tx_push),     32'(vt[i].e_push));
            chk($sformatf("v%0d_run", i),   32'(run_en),      32'(vt[i].e_run));
            chk($sformatf("v%0d_mode", i),  32'(mode),        32'(vt[i].e_mode));
            chk($sformatf("v%0d_clr", i),   32'(clear_pulse), 32'(vt[i].e_clr));
            if (vt[i].chk_data)
                chk($sformatf("v%0d_data", i), 32'(tx_data), 32'(vt[i].e_data));
        end
        rx_valid = 1'b0; btn_run = 1'b0; btn_clear = 1'b0; btn_mode = 1'b0; tx_full = 1'b0;

        do_report("rep1", 16'h1209, 64'h52_44_31_32_30_39_0D_0A, 0, 1'b0, 0);
        do_report("rep2", 16'h1209, 64'h52_44_31_32_30_39_0D_0A, 3, 1'b1, 0);
        #1 chk("rep2_run_after", 32'(run_en), 32'd0);
        do_report("rep3", 16'hA0F9, 64'h50_44_3F_30_3F_39_0D_0A, 0, 1'b0, 0);
        do_report("rep4", 16'h0000, 64'h50_44_30_30_30_30_0D_0A, 0, 1'b0, 3);

        @(posedge clk); #1;
        rst = 1'b0;
        #5;
        chk("abort_run",  32'(run_en),      32'd0);
        chk("abort_mode", 32'(mode),        32'd0);
        chk("abort_clr",  32'(clear_pulse), 32'd0);
        chk("abort_data", 32'(tx_data),     32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #6;
            chk($sformatf("abort_nopush%0d", i), 32'(tx_push), 32'd0);
        end
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 8'h72;
        #5 chk("abort_ready_pop", 32'(rx_pop), 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(posedge clk); #6;
        chk("abort_cmd_run", 32'(run_en), 32'd1);
        chk("abort_cmd_ack", 32'(tx_push), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command sequencer between the UART FIFO datapath and the FND counter. It pops received bytes from the RX FIFO and decodes single-character ASCII commands. It merges those commands with the front-panel button pulses into run, clear and mode controls for the counter. On request it streams an 8-byte status report into the TX FIFO under full/push flow control.

Parameters:
ACK_EN, 1, when 1 every accepted non-status command pushes one ACK byte.
ACK_CHAR, 8'h3E, ACK byte value ('>').

Ports:
clk  input  1  system clock
rst  input  1  reset
btn_run  input  1  debounced single-cycle pulse, toggle run
btn_clear  input  1  debounced single-cycle pulse, clear counter
btn_mode  input  1  debounced single-cycle pulse, toggle count direction
rx_data  input  8  RX FIFO head byte (show-ahead, valid while rx_valid=1)
rx_valid  input  1  RX FIFO not empty
rx_pop  output  1  pop RX FIFO head this cycle
tx_data  output  8  byte to TX FIFO
tx_push  output  1  push tx_data this cycle
tx_full  input  1  TX FIFO full
count_bcd  input  16  current counter value, 4 BCD digits, [15:12] most significant
run_en  output  1  counter running
clear_pulse  output  1  one-cycle counter clear
mode  output  1  0 = count up, 1 = count down

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: run_en=0, mode=0, clear_pulse=0, rx_pop=0, tx_push=0, tx_data=8'h00, FSM=IDLE, byte index=0.
- FSM states: IDLE, DECODE, ACK, REPORT.
- IDLE:
  - If rx_valid=1, drive rx_pop=1 combinationally in that cycle and latch rx_data into cmd_reg.
  - Next state is DECODE.
  - rx_pop is never high outside IDLE.
- DECODE (one cycle), decoding cmd_reg:
  - 'R'/'r': toggle run_en.
  - 'C'/'c': pulse clear_pulse.
  - 'M'/'m': toggle mode.
  - 'S'/'s': snapshot run_en, mode and count_bcd, then go to REPORT with index=0.
  - Any other byte is silently dropped and returns to IDLE. No ACK is sent for it.
  - For R/C/M: go to ACK if ACK_EN=1, otherwise go to IDLE.
- Command latency: rx_pop in cycle n means run_en/mode change is visible from cycle n+2, and clear_pulse is high for exactly cycle n+2.
- Buttons act in any FSM state. A pulse in cycle n takes effect in cycle n+1 (clear_pulse high during n+1).
- Same-function collision: a button pulse and a DECODE of the same function in the same cycle produce a single toggle/pulse, not two. The UART byte is still consumed and still ACKed. Different functions in the same cycle both apply.
- ACK state: holds until tx_full=0, then drives tx_push=1 with tx_data=ACK_CHAR for one cycle, then returns to IDLE.
- REPORT frame, 8 bytes in order:
  - Byte 0: 'R' (0x52) if run snapshot=1, else 'P' (0x50).
  - Byte 1: 'D' (0x44) if mode snapshot=1, else 'U' (0x55).
  - Bytes 2-5: BCD digits from most to least significant, each sent as 8'h30+digit. A digit above 9 is sent as '?' (0x3F).
  - Byte 6: 0x0D. Byte 7: 0x0A.
- REPORT flow control:
  - tx_push=1 only in cycles where tx_full=0. The index advances only on a push.
  - While tx_full=1, tx_push=0 and tx_data holds its value.
  - After byte 7 is pushed, return to IDLE.
  - The frame uses the snapshot. Button activity during a report changes outputs but not the frame contents.
- During ACK/REPORT the RX FIFO is not popped; pending commands wait in the FIFO.
- tx_push is never high in two different meanings in one cycle: at most one byte is pushed per cycle.
- A rst asserted mid-report or mid-ACK aborts immediately. No further tx_push occurs, all outputs return to reset values on the next edge, and the remaining frame bytes are discarded.

Test Plan:
- Reset, then rx_valid=1 with rx_data='r' (0x72) at cycle n -> rx_pop=1 only at n, run_en=1 from n+2, then tx_push of 0x3E once.
- btn_clear pulse together with a UART 'c' decoded in the same cycle -> clear_pulse high for exactly 1 cycle, one ACK pushed.
- count_bcd=16'h1209, run_en=1, mode=1, send 's' with tx_full=0 -> 8 consecutive pushes: 52 44 31 32 30 39 0D 0A.
- Same 's' report with tx_full forced high for 5 cycles after byte 2 -> no push while full, tx_data stable, full frame intact with no byte lost or duplicated.
- Send bytes 'x' then 'm' back-to-back -> 'x' popped and ignored with no ACK; mode=1; exactly one ACK pushed.
- Assert rst for 1 cycle after the 3rd report byte -> no further tx_push, run_en=mode=0, FSM back in IDLE and ready to pop the next byte.
